fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_queue.sv | 57 +++++
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared core constants and small decode helpers used by the fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [6:0]  OPCODE_BRANCH        = 7'b1100011;
  localparam logic [6:0]  OPCODE_OP_IMM        = 7'b0010011;

  // A halfword whose low two bits are not 2'b11 starts a 16-bit instruction.
  function automatic logic is_full_width(input logic [15:0] half);
    return (half[1:0] == 2'b11);
  endfunction

  // Sign-extended B-type immediate (bit 0 is always zero).
  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry word queue between the instruction-memory response port and the aligner.
// Entry 0 is always the oldest word; the aligner also sees the low half of entry 1.
module fetch_queue
  import fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_word,
  input  logic        pop,
  output logic [31:0] head_word,
  output logic [15:0] next_half,
  output logic [1:0]  count
);

  logic [31:0] entry_r [2];
  logic [1:0]  count_r;

  // Storage and occupancy: flush empties, pop shifts entry 1 down, push appends.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      entry_r[0] <= 32'h0000_0000;
      entry_r[1] <= 32'h0000_0000;
      count_r    <= 2'd0;
    end else if (flush) begin
      count_r <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          entry_r[count_r[0]] <= push_word;
          count_r             <= count_r + 2'd1;
        end
        2'b01: begin
          entry_r[0] <= entry_r[1];
          count_r    <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            entry_r[0] <= push_word;
          end else begin
            entry_r[0] <= entry_r[1];
            entry_r[1] <= push_word;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign head_word = entry_r[0];
  assign next_half = entry_r[1][15:0];
  assign count     = count_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: word fetcher, halfword aligner, static backward-branch
// predictor and the registered hand-off to decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        en_excep_program_counter_i,
  input  logic [31:0] excep_program_counter_i,
  input  logic        branch_redirect_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_fetch_stage_i,
  input  logic        flush_fetch_stage_i,
  output logic [31:0] instruction_o,
  output logic [31:0] program_counter_o,
  output logic        branch_taken_o
);

  logic [31:0] fetch_pc_r, pc_r, instr_r, pc_out_r;
  logic        taken_r, run_r;
  logic [1:0]  outst_r, discard_r;

  logic [31:0] q_head_s;
  logic [15:0] q_next_half_s;
  logic [1:0]  q_count_s;

  logic [15:0] half_s;
  logic        is32_s, avail_s, consume_s, predict_s, ext_redirect_s, redirect_s;
  logic        pop_s, push_s, req_valid_s, acc_s;
  logic [31:0] instr_s, target_s, pc_step_s;
  logic [1:0]  outst_next_s;

  fetch_queue u_queue (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush     (redirect_s),
    .push      (push_s),
    .push_word (imem_resp_data_i),
    .pop       (pop_s),
    .head_word (q_head_s),
    .next_half (q_next_half_s),
    .count     (q_count_s)
  );

  // Aligner, predictor, redirect selection and request/response bookkeeping.
  always_comb begin
    half_s         = pc_r[1] ? q_head_s[31:16] : q_head_s[15:0];
    is32_s         = is_full_width(half_s);
    avail_s        = 1'b0;
    instr_s        = {16'h0000, half_s};
    target_s       = 32'h0000_0000;
    pc_step_s      = is32_s ? 32'd4 : 32'd2;

    // A 32-bit instruction straddling two words needs both queue entries.
    if (is32_s && pc_r[1]) begin
      avail_s = (q_count_s == 2'd2);
      instr_s = {q_next_half_s, q_head_s[31:16]};
    end else if (is32_s) begin
      avail_s = (q_count_s != 2'd0);
      instr_s = q_head_s;
    end else begin
      avail_s = (q_count_s != 2'd0);
    end

    ext_redirect_s = en_excep_program_counter_i | branch_redirect_i;
    consume_s      = avail_s & ~stall_fetch_stage_i & ~flush_fetch_stage_i & ~ext_redirect_s;
    predict_s      = consume_s & is32_s & (instr_s[6:0] == OPCODE_BRANCH) & instr_s[31];
    redirect_s     = ext_redirect_s | predict_s;

    if (en_excep_program_counter_i) begin
      target_s = excep_program_counter_i & ~32'h0000_0001;
    end else if (branch_redirect_i) begin
      target_s = branch_target_i & ~32'h0000_0001;
    end else begin
      target_s = (pc_r + imm_b(instr_s)) & ~32'h0000_0001;
    end

    // Leaving the head word: any 32-bit instruction, or a 16-bit one in the upper half.
    pop_s        = consume_s & (is32_s | pc_r[1]);
    req_valid_s  = run_r & (({1'b0, q_count_s} + {1'b0, outst_r}) < 3'd2);
    acc_s        = req_valid_s & imem_req_ready_i;
    push_s       = imem_resp_valid_i & (discard_r == 2'd0) & ~redirect_s;
    outst_next_s = outst_r + {1'b0, acc_s} - {1'b0, imem_resp_valid_i};
  end

  // Fetch/consume addresses, outstanding and discard counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run_r      <= 1'b0;
      fetch_pc_r <= RESET_VECTOR;
      pc_r       <= RESET_VECTOR;
      outst_r    <= 2'd0;
      discard_r  <= 2'd0;
    end else begin
      run_r   <= 1'b1;
      outst_r <= outst_next_s;
      if (redirect_s) begin
        pc_r       <= target_s;
        fetch_pc_r <= target_s & ~32'h0000_0003;
        discard_r  <= outst_next_s;
      end else begin
        if (consume_s) begin
          pc_r <= pc_r + pc_step_s;
        end else begin
          pc_r <= pc_r;
        end
        if (acc_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end else begin
          fetch_pc_r <= fetch_pc_r;
        end
        if (imem_resp_valid_i && (discard_r != 2'd0)) begin
          discard_r <= discard_r - 2'd1;
        end else begin
          discard_r <= discard_r;
        end
      end
    end
  end

  // Decode hand-off register: kill beats stall, stall holds, otherwise instruction or bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_r  <= NOP_INSTR;
      pc_out_r <= RESET_VECTOR;
      taken_r  <= 1'b0;
    end else if (flush_fetch_stage_i || ext_redirect_s) begin
      instr_r <= NOP_INSTR;
      taken_r <= 1'b0;
    end else if (stall_fetch_stage_i) begin
      instr_r <= instr_r;
      taken_r <= taken_r;
    end else if (consume_s) begin
      instr_r  <= instr_s;
      pc_out_r <= pc_r;
      taken_r  <= predict_s;
    end else begin
      instr_r <= NOP_INSTR;
      taken_r <= 1'b0;
    end
  end

  assign imem_req_valid_o  = req_valid_s;
  assign imem_req_addr_o   = fetch_pc_r;
  assign instruction_o     = instr_r;
  assign program_counter_o = pc_out_r;
  assign branch_taken_o    = taken_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order, fixed-latency instruction memory.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        excep_en, br_redirect, stall, flush;
  logic [31:0] excep_pc, br_target;
  logic [31:0] instr_out, pc_out;
  logic        taken_out;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] mem [0:255];
  int lat = 1;
  int cyc = 0;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend_q[$];

  fetch_stage #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk_i                      (clk),
    .rst_i                      (rst_n),
    .imem_req_valid_o           (req_valid),
    .imem_req_ready_i           (req_ready),
    .imem_req_addr_o            (req_addr),
    .imem_resp_valid_i          (resp_valid),
    .imem_resp_data_i           (resp_data),
    .en_excep_program_counter_i (excep_en),
    .excep_program_counter_i    (excep_pc),
    .branch_redirect_i          (br_redirect),
    .branch_target_i            (br_target),
    .stall_fetch_stage_i        (stall),
    .flush_fetch_stage_i        (flush),
    .instruction_o              (instr_out),
    .program_counter_o          (pc_out),
    .branch_taken_o             (taken_out)
  );

  always #5 clk = ~clk;

  // Memory model: works on the falling edge so its outputs are stable at the rising edge.
  initial begin
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend_q.delete();
        resp_valid = 1'b0;
      end else begin
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          resp_valid = 1'b1;
          resp_data  = mem[pend_q[0].addr[9:2]];
          void'(pend_q.pop_front());
        end else begin
          resp_valid = 1'b0;
        end
        if (req_valid && req_ready) pend_q.push_back('{addr: req_addr, due: cyc + lat});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = NOP;
  endtask

  task automatic do_reset(input int latency);
    lat         = latency;
    rst_n       = 1'b0;
    req_ready   = 1'b1;
    excep_en    = 1'b0;
    excep_pc    = 32'h0;
    br_redirect = 1'b0;
    br_target   = 32'h0;
    stall       = 1'b0;
    flush       = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Advance to the next cycle that hands a non-NOP instruction to decode, then check it.
  task automatic next_instr(input string tag, input logic [31:0] e_instr,
                            input logic [31:0] e_pc, input logic e_taken);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (instr_out !== NOP) found = 1'b1;
    end
    check_bit({tag, " seen"}, found, 1'b1);
    check32({tag, " instr"}, instr_out, e_instr);
    check32({tag, " pc"}, pc_out, e_pc);
    check_bit({tag, " taken"}, taken_out, e_taken);
  endtask

  initial begin
    // Reset state and two aligned 32-bit instructions.
    clear_mem();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_8113;
    do_reset(1);
    check32("rst instr", instr_out, NOP);
    check32("rst pc", pc_out, 32'h0);
    check_bit("rst taken", taken_out, 1'b0);
    check_bit("rst req_valid", req_valid, 1'b0);
    next_instr("t1 i0", 32'h0050_0093, 32'h0, 1'b0);
    next_instr("t1 i1", 32'h0010_8113, 32'h4, 1'b0);

    // Two compressed instructions in one word.
    clear_mem();
    mem[0] = 32'h4501_4505;
    do_reset(1);
    next_instr("t2 c0", 32'h0000_4505, 32'h0, 1'b0);
    next_instr("t2 c1", 32'h0000_4501, 32'h2, 1'b0);

    // 32-bit instruction assembled across a word boundary.
    clear_mem();
    mem[0] = 32'h0093_4505;
    mem[1] = 32'h0000_0050;
    do_reset(1);
    next_instr("t3 c0", 32'h0000_4505, 32'h0, 1'b0);
    next_instr("t3 split", 32'h0050_0093, 32'h2, 1'b0);

    // Backward branch at 0x10 with offset -8 is predicted taken.
    clear_mem();
    mem[2] = 32'h0010_0093;
    mem[3] = 32'h0020_0113;
    mem[4] = 32'hFE00_0CE3;
    mem[5] = 32'h0030_0193;
    do_reset(1);
    next_instr("t4 a", 32'h0010_0093, 32'h8, 1'b0);
    next_instr("t4 b", 32'h0020_0113, 32'hC, 1'b0);
    next_instr("t4 br", 32'hFE00_0CE3, 32'h10, 1'b1);
    next_instr("t4 tgt", 32'h0010_0093, 32'h8, 1'b0);

    // Execute redirect with two requests in flight: both stale responses dropped.
    clear_mem();
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'h0010_8113;
    mem[64] = 32'h00A0_0513;
    do_reset(4);
    for (int i = 0; i < 10 && pend_q.size() < 2; i++) step();
    check32("t5 inflight", 32'(pend_q.size()), 32'd2);
    br_redirect = 1'b1;
    br_target   = 32'h0000_0100;
    step();
    br_redirect = 1'b0;
    check32("t5 kill instr", instr_out, NOP);
    next_instr("t5 tgt", 32'h00A0_0513, 32'h100, 1'b0);

    // Three-cycle stall with a flush in the middle.
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = {12'(i + 1), 5'd0, 3'b000, 5'd1, 7'b0010011};
    do_reset(1);
    next_instr("t6 i0", mem[0], 32'h0, 1'b0);
    next_instr("t6 i1", mem[1], 32'h4, 1'b0);
    stall = 1'b1;
    step();
    check32("t6 hold instr", instr_out, mem[1]);
    check32("t6 hold pc", pc_out, 32'h4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check32("t6 flush instr", instr_out, NOP);
    check32("t6 flush pc", pc_out, 32'h4);
    check_bit("t6 flush taken", taken_out, 1'b0);
    step();
    check32("t6 stall nop", instr_out, NOP);
    stall = 1'b0;
    next_instr("t6 resume", mem[2], 32'h8, 1'b0);

    // Exception outranks execute redirect; target bit 0 cleared.
    clear_mem();
    mem[0]  = 32'h0050_0093;
    mem[16] = 32'h0070_0393;
    mem[64] = 32'h00A0_0513;
    do_reset(1);
    next_instr("t7 i0", 32'h0050_0093, 32'h0, 1'b0);
    excep_en    = 1'b1;
    excep_pc    = 32'h0000_0101;
    br_redirect = 1'b1;
    br_target   = 32'h0000_0040;
    step();
    excep_en    = 1'b0;
    br_redirect = 1'b0;
    check32("t7 kill instr", instr_out, NOP);
    check_bit("t7 kill taken", taken_out, 1'b0);
    next_instr("t7 tgt", 32'h00A0_0513, 32'h100, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
